// File: rtl/i2c_slave_responder.sv
// ---------------------------------------------------------------------------
// i2c_slave_responder
//
// I2C target with a 7-bit address, backed by a small byte register file that
// behaves like a serial EEPROM. After the address byte with R/W=0, the first
// data byte sets the pointer. Each later data byte is written at the pointer,
// and the pointer then increments. A read (R/W=1) returns bytes starting at
// the pointer and also increments it. SCL and SDA are oversampled on clk_i.
// This block never stretches the clock.
//
// Ports
//   clk_i      system clock
//   rst_i      synchronous active-high reset
//   scl_i      bus clock (input only)
//   sda_i      bus data as seen on the wire
//   sda_o      open-drain data drive: 0 = pull low, 1 = release
//   loc_we     local write strobe into the register file
//   loc_addr   local register address
//   loc_wdata  local write data
//   loc_rdata  mem[loc_addr], registered, one-cycle latency
//   busy       high from an addressed START until STOP
//   wr_strobe  one-cycle pulse for each data byte stored from the bus
//   wr_addr    register address of that byte, valid with wr_strobe
// ---------------------------------------------------------------------------
module i2c_slave_responder #(
    parameter int                I2C_AW     = 7,
    parameter logic [I2C_AW-1:0] SLAVE_ADDR = 7'h22,
    parameter int                MEM_AW     = 5,
    parameter int                I2C_DW     = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_o,
    input  logic              loc_we,
    input  logic [MEM_AW-1:0] loc_addr,
    input  logic [I2C_DW-1:0] loc_wdata,
    output logic [I2C_DW-1:0] loc_rdata,
    output logic              busy,
    output logic              wr_strobe,
    output logic [MEM_AW-1:0] wr_addr
);

    localparam int            MEM_DEPTH = 1 << MEM_AW;
    localparam logic [3:0]    LAST_BIT  = 4'(I2C_DW - 1);
    localparam logic [3:0]    BYTE_BITS = 4'(I2C_DW);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_WR_DATA,
        S_WR_ACK,
        S_RD_DATA,
        S_RD_ACK,
        S_IGNORE
    } state_t;

    // -----------------------------------------------------------------------
    // Input synchronisers. Bits [1:0] are the two-flop synchroniser, and
    // bit [1] is the synced value. Bit [2] holds the previous synced value
    // for edge detection. The flops reset to 1, which is the idle bus level.
    // -----------------------------------------------------------------------
    logic [2:0] scl_pipe_reg;
    logic [2:0] sda_pipe_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_pipe_reg <= 3'b111;
            sda_pipe_reg <= 3'b111;
        end else begin
            scl_pipe_reg <= {scl_pipe_reg[1:0], scl_i};
            sda_pipe_reg <= {sda_pipe_reg[1:0], sda_i};
        end
    end

    logic scl_sync, sda_sync;
    logic scl_rise, scl_fall;
    logic start_evt, stop_evt;

    assign scl_sync  = scl_pipe_reg[1];
    assign sda_sync  = sda_pipe_reg[1];
    assign scl_rise  =  scl_pipe_reg[1] & ~scl_pipe_reg[2];
    assign scl_fall  = ~scl_pipe_reg[1] &  scl_pipe_reg[2];
    assign start_evt =  scl_sync & ~sda_pipe_reg[1] &  sda_pipe_reg[2];
    assign stop_evt  =  scl_sync &  sda_pipe_reg[1] & ~sda_pipe_reg[2];

    // -----------------------------------------------------------------------
    // Register file: two read ports (bus side and local side), both
    // registered. A local write and a bus write to the same address in the
    // same cycle both reach this block. The bus write is last, so it wins.
    // -----------------------------------------------------------------------
    logic [I2C_DW-1:0] mem [MEM_DEPTH];
    logic [I2C_DW-1:0] loc_rdata_reg;
    logic [I2C_DW-1:0] mem_rdata_reg;

    // -----------------------------------------------------------------------
    // Protocol state
    // -----------------------------------------------------------------------
    state_t            state_reg,      state_next;
    logic [3:0]        bit_cnt_reg,    bit_cnt_next;
    logic [I2C_DW-1:0] sr_reg,         sr_next;
    logic              sda_o_reg,      sda_o_next;
    logic              busy_reg,       busy_next;
    logic              rw_reg,         rw_next;
    logic              first_byte_reg, first_byte_next;
    logic [MEM_AW-1:0] ptr_reg,        ptr_next;
    logic              wr_strobe_reg,  wr_strobe_next;
    logic [MEM_AW-1:0] wr_addr_reg,    wr_addr_next;
    logic              i2c_we;
    logic [I2C_DW-1:0] rx_byte;

    // rx_byte is the byte as it stands once the bit sampled on this
    // SCL rising edge has been shifted in.
    assign rx_byte = {sr_reg[I2C_DW-2:0], sda_sync};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg      <= S_IDLE;
            bit_cnt_reg    <= '0;
            sr_reg         <= '0;
            sda_o_reg      <= 1'b1;
            busy_reg       <= 1'b0;
            rw_reg         <= 1'b0;
            first_byte_reg <= 1'b0;
            ptr_reg        <= '0;
            wr_strobe_reg  <= 1'b0;
            wr_addr_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            bit_cnt_reg    <= bit_cnt_next;
            sr_reg         <= sr_next;
            sda_o_reg      <= sda_o_next;
            busy_reg       <= busy_next;
            rw_reg         <= rw_next;
            first_byte_reg <= first_byte_next;
            ptr_reg        <= ptr_next;
            wr_strobe_reg  <= wr_strobe_next;
            wr_addr_reg    <= wr_addr_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        sr_next         = sr_reg;
        sda_o_next      = sda_o_reg;
        busy_next       = busy_reg;
        rw_next         = rw_reg;
        first_byte_next = first_byte_reg;
        ptr_next        = ptr_reg;
        wr_strobe_next  = 1'b0;
        wr_addr_next    = wr_addr_reg;
        i2c_we          = 1'b0;

        if (start_evt) begin
            // A START or repeated START drops any partial byte.
            state_next   = S_ADDR;
            bit_cnt_next = '0;
            sda_o_next   = 1'b1;
        end else if (stop_evt) begin
            state_next = S_IDLE;
            sda_o_next = 1'b1;
            busy_next  = 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                end

                S_ADDR: begin
                    if (scl_rise) begin
                        sr_next = rx_byte;
                        if (bit_cnt_reg == LAST_BIT) begin
                            bit_cnt_next = '0;
                            if (rx_byte[I2C_DW-1 -: I2C_AW] == SLAVE_ADDR) begin
                                rw_next    = rx_byte[0];
                                busy_next  = 1'b1;
                                state_next = S_ADDR_ACK;
                            end else begin
                                state_next = S_IGNORE;
                            end
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 1'b1;
                        end
                    end
                end

                // The 8th falling edge pulls SDA low. The 9th rising edge
                // ends the ACK bit. The 9th falling edge belongs to the next
                // state: it either releases SDA (write) or drives the first
                // read bit (read).
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        sda_o_next = 1'b0;
                    end else if (scl_rise) begin
                        bit_cnt_next = '0;
                        if (rw_reg) begin
                            sr_next    = mem_rdata_reg;
                            state_next = S_RD_DATA;
                        end else begin
                            first_byte_next = 1'b1;
                            state_next      = S_WR_DATA;
                        end
                    end
                end

                S_WR_DATA: begin
                    if (scl_fall) begin
                        sda_o_next = 1'b1;
                    end else if (scl_rise) begin
                        sr_next = rx_byte;
                        if (bit_cnt_reg == LAST_BIT) begin
                            bit_cnt_next = '0;
                            state_next   = S_WR_ACK;
                            if (first_byte_reg) begin
                                ptr_next        = rx_byte[MEM_AW-1:0];
                                first_byte_next = 1'b0;
                            end else begin
                                i2c_we         = 1'b1;
                                wr_strobe_next = 1'b1;
                                wr_addr_next   = ptr_reg;
                                ptr_next       = ptr_reg + 1'b1;
                            end
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 1'b1;
                        end
                    end
                end

                S_WR_ACK: begin
                    if (scl_fall) begin
                        sda_o_next = 1'b0;
                    end else if (scl_rise) begin
                        state_next = S_WR_DATA;
                    end
                end

                // bit_cnt counts the falling edges driven so far in this
                // byte. Edges 0..7 put bits out MSB first. Edge 8 releases
                // SDA so the master can ACK.
                S_RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_reg == BYTE_BITS) begin
                            sda_o_next   = 1'b1;
                            ptr_next     = ptr_reg + 1'b1;
                            bit_cnt_next = '0;
                            state_next   = S_RD_ACK;
                        end else begin
                            sda_o_next   = sr_reg[I2C_DW-1];
                            sr_next      = {sr_reg[I2C_DW-2:0], 1'b0};
                            bit_cnt_next = bit_cnt_reg + 1'b1;
                        end
                    end
                end

                // The pointer advanced at least one SCL half-period ago.
                // That gives mem_rdata_reg time to reflect the next byte.
                S_RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_sync) begin
                            sr_next      = mem_rdata_reg;
                            bit_cnt_next = '0;
                            state_next   = S_RD_DATA;
                        end else begin
                            state_next = S_IGNORE;
                        end
                    end
                end

                S_IGNORE: begin
                    sda_o_next = 1'b1;
                end

                default: begin
                    state_next = S_IDLE;
                    sda_o_next = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (loc_we) begin
            mem[loc_addr] <= loc_wdata;
        end
        if (i2c_we && !rst_i) begin
            mem[ptr_reg] <= rx_byte;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            loc_rdata_reg <= '0;
            mem_rdata_reg <= '0;
        end else begin
            loc_rdata_reg <= mem[loc_addr];
            mem_rdata_reg <= mem[ptr_reg];
        end
    end

    assign sda_o     = sda_o_reg;
    assign busy      = busy_reg;
    assign wr_strobe = wr_strobe_reg;
    assign wr_addr   = wr_addr_reg;
    assign loc_rdata = loc_rdata_reg;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// ---------------------------------------------------------------------------
// Bench for i2c_slave_responder. A behavioural bus master drives SCL and SDA.
// SDA is modelled as a wired-AND of the master and the target. The
// local-port preload and readback use a vector table. The I2C scenarios are
// written out as sequences.
// ---------------------------------------------------------------------------
module tb_i2c_slave_responder;

    localparam int H = 4;   // quarter SCL period in clk_i cycles

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       scl_m, sda_m;
    logic       sda_bus;
    logic       sda_o;
    logic       loc_we;
    logic [4:0] loc_addr;
    logic [7:0] loc_wdata;
    logic [7:0] loc_rdata;
    logic       busy;
    logic       wr_strobe;
    logic [4:0] wr_addr;

    assign sda_bus = sda_m & sda_o;

    always #5 clk_i = ~clk_i;

    i2c_slave_responder dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .scl_i     (scl_m),
        .sda_i     (sda_bus),
        .sda_o     (sda_o),
        .loc_we    (loc_we),
        .loc_addr  (loc_addr),
        .loc_wdata (loc_wdata),
        .loc_rdata (loc_rdata),
        .busy      (busy),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr)
    );

    int checks = 0;
    int errors = 0;

    // Monitor: logs write strobes and counts the cycles in which the
    // target pulls SDA low or reports busy.
    int         strobe_n = 0;
    logic [4:0] strobe_log [64];
    int         low_cnt  = 0;
    int         busy_cnt = 0;

    always @(negedge clk_i) begin
        if (wr_strobe) begin
            strobe_log[strobe_n[5:0]] = wr_addr;
            strobe_n = strobe_n + 1;
        end
        if (!sda_o) low_cnt = low_cnt + 1;
        if (busy) busy_cnt = busy_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish, act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // Each bus task starts and ends with SCL low, except the first START
    // out of an idle bus.
    task automatic i2c_start();
        sda_m = 1'b1; wait_clk(H);
        scl_m = 1'b1; wait_clk(H);
        sda_m = 1'b0; wait_clk(H);
        scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_clk(H); sda_m = 1'b0;
        wait_clk(H); scl_m = 1'b1;
        wait_clk(H); sda_m = 1'b1;
        wait_clk(H);
    endtask

    task automatic bit_xfer(input logic d, output logic s);
        wait_clk(H); sda_m = d;
        wait_clk(H); scl_m = 1'b1;
        wait_clk(H); s = sda_bus;
        wait_clk(H); scl_m = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic dummy;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], dummy);
        bit_xfer(1'b1, ack);
    endtask

    task automatic recv_byte(input logic ack_in, output logic [7:0] b);
        logic dummy;
        for (int i = 7; i >= 0; i--) bit_xfer(1'b1, b[i]);
        bit_xfer(ack_in, dummy);
    endtask

    task automatic loc_read(input logic [4:0] a, output logic [7:0] d);
        loc_we = 1'b0; loc_addr = a;
        @(negedge clk_i);
        d = loc_rdata;
    endtask

    typedef struct {
        logic       we;
        logic [4:0] addr;
        logic [7:0] wdata;
        logic       chk;
        logic [7:0] exp;
    } loc_vec_t;

    loc_vec_t vecs [10];

    initial begin
        logic       ack, seen;
        logic [7:0] rd;
        logic [7:0] addr_w;
        logic [7:0] exp_rd [4];
        int         sbase, lbase, bbase;

        vecs[0] = '{1'b1, 5'd0, 8'h10, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 5'd1, 8'h11, 1'b0, 8'h00};
        vecs[2] = '{1'b1, 5'd2, 8'h12, 1'b0, 8'h00};
        vecs[3] = '{1'b1, 5'd3, 8'h13, 1'b0, 8'h00};
        vecs[4] = '{1'b1, 5'd7, 8'h55, 1'b0, 8'h00};
        vecs[5] = '{1'b1, 5'd8, 8'h5A, 1'b0, 8'h00};
        vecs[6] = '{1'b0, 5'd0, 8'h00, 1'b1, 8'h10};
        vecs[7] = '{1'b0, 5'd3, 8'h00, 1'b1, 8'h13};
        vecs[8] = '{1'b0, 5'd7, 8'h00, 1'b1, 8'h55};
        vecs[9] = '{1'b0, 5'd8, 8'h00, 1'b1, 8'h5A};

        rst_i = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
        loc_we = 1'b0; loc_addr = '0; loc_wdata = '0;
        wait_clk(3);
        check("reset_sda_o",     32'(sda_o),     32'h1);
        check("reset_busy",      32'(busy),      32'h0);
        check("reset_wr_strobe", 32'(wr_strobe), 32'h0);
        check("reset_wr_addr",   32'(wr_addr),   32'h0);
        check("reset_loc_rdata", 32'(loc_rdata), 32'h0);
        rst_i = 1'b0;
        wait_clk(2);

        // Local port table: preload, then read back.
        for (int i = 0; i < 10; i++) begin
            loc_we = vecs[i].we; loc_addr = vecs[i].addr; loc_wdata = vecs[i].wdata;
            @(negedge clk_i);
            loc_we = 1'b0;
            if (vecs[i].chk) check($sformatf("loc_vec%0d", i), 32'(loc_rdata), 32'(vecs[i].exp));
        end
        wait_clk(4);

        // Write: pointer 5, then A1 and B2.
        sbase = strobe_n;
        i2c_start();
        send_byte(8'h44, ack); check("wr_addr_ack", 32'(ack), 32'h0);
        check("wr_busy_mid", 32'(busy), 32'h1);
        send_byte(8'h05, ack); check("wr_ptr_ack", 32'(ack), 32'h0);
        send_byte(8'hA1, ack); check("wr_d0_ack", 32'(ack), 32'h0);
        send_byte(8'hB2, ack); check("wr_d1_ack", 32'(ack), 32'h0);
        i2c_stop();
        wait_clk(4);
        check("wr_busy_after", 32'(busy), 32'h0);
        check("wr_strobe_cnt", 32'(strobe_n - sbase), 32'd2);
        check("wr_strobe0_addr", 32'(strobe_log[sbase[5:0]]), 32'd5);
        check("wr_strobe1_addr", 32'(strobe_log[6'(sbase + 1)]), 32'd6);
        loc_read(5'd5, rd); check("wr_mem5", 32'(rd), 32'hA1);
        loc_read(5'd6, rd); check("wr_mem6", 32'(rd), 32'hB2);

        // Read through a repeated start.
        exp_rd[0] = 8'h10; exp_rd[1] = 8'h11; exp_rd[2] = 8'h12; exp_rd[3] = 8'h13;
        i2c_start();
        send_byte(8'h44, ack); check("rd_waddr_ack", 32'(ack), 32'h0);
        send_byte(8'h00, ack); check("rd_ptr_ack", 32'(ack), 32'h0);
        i2c_start();
        send_byte(8'h45, ack); check("rd_raddr_ack", 32'(ack), 32'h0);
        for (int i = 0; i < 4; i++) begin
            recv_byte((i == 3) ? 1'b1 : 1'b0, rd);
            check($sformatf("rd_byte%0d", i), 32'(rd), 32'(exp_rd[i]));
        end
        lbase = low_cnt;
        i2c_stop();
        wait_clk(4);
        check("rd_no_drive_after_nack", 32'(low_cnt - lbase), 32'd0);
        check("rd_busy_after", 32'(busy), 32'h0);

        // Address mismatch.
        lbase = low_cnt; bbase = busy_cnt;
        i2c_start();
        send_byte(8'h46, ack); check("mm_addr_nack", 32'(ack), 32'h1);
        send_byte(8'h00, ack);
        send_byte(8'hFF, ack);
        i2c_stop();
        wait_clk(4);
        check("mm_sda_never_low", 32'(low_cnt - lbase), 32'd0);
        check("mm_busy_never", 32'(busy_cnt - bbase), 32'd0);
        loc_read(5'd0, rd); check("mm_mem0", 32'(rd), 32'h10);

        // Pointer wrap. Pointer byte 0xFF keeps only its low 5 bits (0x1F).
        sbase = strobe_n;
        i2c_start();
        send_byte(8'h44, ack);
        send_byte(8'hFF, ack);
        send_byte(8'hAA, ack);
        send_byte(8'hBB, ack); check("wrap_d1_ack", 32'(ack), 32'h0);
        i2c_stop();
        wait_clk(4);
        check("wrap_strobe0_addr", 32'(strobe_log[sbase[5:0]]), 32'd31);
        check("wrap_strobe1_addr", 32'(strobe_log[6'(sbase + 1)]), 32'd0);
        loc_read(5'd31, rd); check("wrap_mem31", 32'(rd), 32'hAA);
        loc_read(5'd0, rd);  check("wrap_mem0", 32'(rd), 32'hBB);

        // Reset while the address ACK pulls SDA low.
        addr_w = 8'h44;
        i2c_start();
        for (int i = 7; i >= 0; i--) bit_xfer(addr_w[i], ack);
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk_i);
            if (!sda_o) seen = 1'b1;
        end
        check("rst_ack_driven", 32'(seen), 32'h1);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("rst_sda_released", 32'(sda_o), 32'h1);
        check("rst_busy", 32'(busy), 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        wait_clk(2);
        i2c_start();
        send_byte(8'h44, ack); check("post_rst_ack", 32'(ack), 32'h0);
        i2c_stop();
        wait_clk(4);

        // STOP after 4 data bits: the partial byte is discarded.
        sbase = strobe_n;
        i2c_start();
        send_byte(8'h44, ack);
        send_byte(8'h07, ack); check("abort_ptr_ack", 32'(ack), 32'h0);
        bit_xfer(1'b1, ack); bit_xfer(1'b0, ack);
        bit_xfer(1'b1, ack); bit_xfer(1'b0, ack);
        i2c_stop();
        wait_clk(4);
        check("abort_no_strobe", 32'(strobe_n - sbase), 32'd0);
        check("abort_busy", 32'(busy), 32'h0);
        loc_read(5'd7, rd); check("abort_mem7", 32'(rd), 32'h55);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
